mlp_mac_array: RTL

- Multi-lane, pipelined, fixed-point multiply-accumulate engine for the MLP datapath. Successor to the single-lane MAC.
- One activation `a` is broadcast to N_LANES lanes. Each lane has its own weight `b[i]` and accumulator, so one neuron per lane.
- Adds a `last` marker, a registered `out_valid` pulse, and round-half-up plus saturation to OUT_WIDTH.
- Sits between the weight/activation memories and the activation-function stage.

---
 rtl/mlp_mac_array.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/mlp_mac_array.sv
// mlp_mac_array: multi-lane pipelined fixed-point MAC for the MLP datapath.
// One activation is broadcast to N_LANES lanes, each with its own weight and
// accumulator (one neuron per lane). Results are rounded half-up, saturated
// to OUT_WIDTH and presented with a one-cycle out_valid pulse.
//
// Ports:
//   clk, rst_n            clock / async active-low reset
//   start                 beat that restarts the accumulation (acc := a*b)
//   valid                 beat that accumulates (acc += a*b)
//   last                  marks the current beat as the last of a vector
//   a     [A_WIDTH]       signed activation, shared by all lanes
//   b     [N*B_WIDTH]     signed weights, lane i at b[i*B_WIDTH +: B_WIDTH]
//   out_valid             one-cycle pulse, result/sat_flag updated
//   result[N*OUT_WIDTH]   rounded, saturated lane results (same packing as b)
//   sat_flag[N]           per-lane clip indicator for the current result
//   busy                  a beat is in stage 1 or a last beat is in stage 2
//
// Pipeline: edge k registers the products, edge k+1 updates accumulators,
// edge k+2 rounds/saturates a finished vector. Each stage carries its own
// flags, so back-to-back single-beat vectors never interfere.

// Per-lane datapath: product register, accumulator, round/saturate output.
module mlp_mac_lane #(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int FRAC_BITS = 8,
  parameter int ACC_WIDTH = 48,
  parameter int OUT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        beat,
  input  logic                        s1_start,
  input  logic                        s1_acc,
  input  logic                        s2_last,
  input  logic signed [A_WIDTH-1:0]   a,
  input  logic signed [B_WIDTH-1:0]   b,
  output logic [OUT_WIDTH-1:0]        result,
  output logic                        sat_flag
);
  localparam int PW = A_WIDTH + B_WIDTH;
  localparam int HALF_SH = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
  // One extra bit so adding the rounding constant can never wrap.
  localparam logic signed [ACC_WIDTH:0] HALF =
    (FRAC_BITS > 0) ? ((ACC_WIDTH+1)'(1) <<< HALF_SH) : '0;
  localparam logic signed [ACC_WIDTH:0] OUT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] OUT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic signed [PW-1:0]        prod_q, prod_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [OUT_WIDTH-1:0]        result_q, result_d;
  logic                        sat_q, sat_d;
  logic signed [ACC_WIDTH:0]   rnd, shr;

  always_comb begin
    // product only captured on beats; bubbles leave it (and power) alone
    prod_d = prod_q;
    if (beat) prod_d = a * b;

    acc_d = acc_q;
    if (s1_start)    acc_d = ACC_WIDTH'(prod_q);
    else if (s1_acc) acc_d = acc_q + ACC_WIDTH'(prod_q);

    // round half toward +inf, then clip to the output range
    rnd = (ACC_WIDTH+1)'(acc_q) + HALF;
    shr = rnd >>> FRAC_BITS;

    result_d = result_q;
    sat_d    = sat_q;
    if (s2_last) begin
      if (shr > OUT_MAX) begin
        result_d = OUT_MAX[OUT_WIDTH-1:0];
        sat_d    = 1'b1;
      end else if (shr < OUT_MIN) begin
        result_d = OUT_MIN[OUT_WIDTH-1:0];
        sat_d    = 1'b1;
      end else begin
        result_d = shr[OUT_WIDTH-1:0];
        sat_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      sat_q    <= 1'b0;
    end else begin
      prod_q   <= prod_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      sat_q    <= sat_d;
    end
  end

  assign result   = result_q;
  assign sat_flag = sat_q;
endmodule

module mlp_mac_array #(
  parameter int N_LANES   = 4,
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int FRAC_BITS = 8,
  parameter int ACC_WIDTH = 48,
  parameter int OUT_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           valid,
  input  logic                           last,
  input  logic [A_WIDTH-1:0]             a,
  input  logic [N_LANES*B_WIDTH-1:0]     b,
  output logic                           out_valid,
  output logic [N_LANES*OUT_WIDTH-1:0]   result,
  output logic [N_LANES-1:0]             sat_flag,
  output logic                           busy
);
  localparam int STAGES = 3;

  logic [N_LANES-1:0][B_WIDTH-1:0]   b_lane;
  logic [N_LANES-1:0][OUT_WIDTH-1:0] result_lane;

  // vld_pipe carries the "vector finished" token: [1]=s1_last,
  // [2]=s2_last, [3]=out_valid.
  logic [STAGES:1] vld_pipe_q, vld_pipe_d;
  logic            s1_start_q, s1_start_d;
  logic            s1_acc_q, s1_acc_d;
  logic            beat;

  assign beat = start | valid;

  always_comb begin
    // start wins over valid; every flag clears on a bubble
    s1_start_d    = start;
    s1_acc_d      = valid & ~start;
    vld_pipe_d[1] = last & beat;
    vld_pipe_d[2] = vld_pipe_q[1] & (s1_start_q | s1_acc_q);
    vld_pipe_d[3] = vld_pipe_q[2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_start_q <= 1'b0;
      s1_acc_q   <= 1'b0;
      vld_pipe_q <= '0;
    end else begin
      s1_start_q <= s1_start_d;
      s1_acc_q   <= s1_acc_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  assign b_lane = b;

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    mlp_mac_lane #(
      .A_WIDTH  (A_WIDTH),
      .B_WIDTH  (B_WIDTH),
      .FRAC_BITS(FRAC_BITS),
      .ACC_WIDTH(ACC_WIDTH),
      .OUT_WIDTH(OUT_WIDTH)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .beat    (beat),
      .s1_start(s1_start_q),
      .s1_acc  (s1_acc_q),
      .s2_last (vld_pipe_q[2]),
      .a       (a),
      .b       (b_lane[i]),
      .result  (result_lane[i]),
      .sat_flag(sat_flag[i])
    );
  end

  assign result    = result_lane;
  assign out_valid = vld_pipe_q[3];
  assign busy      = s1_start_q | s1_acc_q | vld_pipe_q[2];
endmodule
